// File: rtl/mtr_cmd_shaper.sv
`default_nettype none
// ============================================================================
// Module   : mtr_cmd_shaper (with per-wheel helper mtr_cmd_side)
// Brief    : Converts signed per-wheel drive commands into magnitude/direction
//            motor-driver commands. Applies deadzone rejection, minimum-duty
//            offset, saturation and slew-rate limiting, and forces every
//            direction reversal through zero speed followed by a dwell period.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// One wheel: target derivation plus the RUN / RAMP_DN / DWELL sequencer.
// ----------------------------------------------------------------------------
module mtr_cmd_side #(
    parameter int SLEW        = 16,
    parameter int DEADZONE    = 32,
    parameter int MIN_DUTY    = 128,
    parameter int DWELL_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_i,
    input  logic        en_i,
    input  logic [11:0] cmd_i,
    output logic [10:0] spd_o,
    output logic        rev_o,
    output logic [10:0] tgt_o,
    output logic        run_o
);

    localparam int          c_dw_w = $clog2(DWELL_TICKS + 1);
    localparam logic [10:0] c_slew = 11'(SLEW);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RAMP_DN = 2'd1,
        ST_DWELL   = 2'd2
    } state_t;

    state_t              state_q;
    logic [10:0]         spd_q;
    logic                rev_q;
    logic [c_dw_w-1:0]   dwell_q;

    logic [11:0]         w_mag;
    logic [12:0]         w_sum;
    logic [10:0]         w_tgt;
    logic                w_tdir;

    // Target magnitude and requested direction from the latched command
    always_comb begin
        w_mag = cmd_i[11] ? (~cmd_i + 12'd1) : cmd_i;   // -2048 maps to 2048
        w_sum = {1'b0, w_mag} + 13'(MIN_DUTY);
        if ({20'd0, w_mag} < 32'(DEADZONE)) begin
            w_tgt = 11'd0;
        end else if (w_sum > 13'd2047) begin
            w_tgt = 11'h7FF;
        end else begin
            w_tgt = w_sum[10:0];
        end
        // A zero target never requests a reversal
        w_tdir = (w_tgt == 11'd0) ? rev_q : cmd_i[11];
    end

    // Sequencer: slew toward target, or ramp down and dwell before a flip
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            spd_q   <= 11'd0;
            rev_q   <= 1'b0;
            dwell_q <= '0;
        end else if (!en_i) begin
            // Disabled: immediate zero speed, direction remembered
            state_q <= ST_RUN;
            spd_q   <= 11'd0;
        end else if (tick_i) begin
            case (state_q)
                ST_RUN: begin
                    if (w_tdir == rev_q) begin
                        if (spd_q < w_tgt) begin
                            spd_q <= ((w_tgt - spd_q) > c_slew) ? (spd_q + c_slew) : w_tgt;
                        end else begin
                            spd_q <= ((spd_q - w_tgt) > c_slew) ? (spd_q - c_slew) : w_tgt;
                        end
                    end else if (spd_q != 11'd0) begin
                        state_q <= ST_RAMP_DN;
                    end else begin
                        state_q <= ST_DWELL;
                        dwell_q <= c_dw_w'(DWELL_TICKS);
                    end
                end
                ST_RAMP_DN: begin
                    if (w_tdir == rev_q) begin
                        state_q <= ST_RUN;
                    end else if (spd_q <= c_slew) begin
                        spd_q   <= 11'd0;
                        state_q <= ST_DWELL;
                        dwell_q <= c_dw_w'(DWELL_TICKS);
                    end else begin
                        spd_q <= spd_q - c_slew;
                    end
                end
                ST_DWELL: begin
                    if (w_tdir == rev_q) begin
                        state_q <= ST_RUN;
                    end else if (dwell_q <= c_dw_w'(1)) begin
                        // Last dwell tick: flip direction while speed is zero
                        dwell_q <= '0;
                        rev_q   <= ~rev_q;
                        state_q <= ST_RUN;
                    end else begin
                        dwell_q <= dwell_q - c_dw_w'(1);
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign spd_o = spd_q;
    assign rev_o = rev_q;
    assign tgt_o = w_tgt;
    assign run_o = (state_q == ST_RUN);

endmodule

// ----------------------------------------------------------------------------
// Top: command latch, slew-tick prescaler, two wheel instances, settled flag.
// ----------------------------------------------------------------------------
module mtr_cmd_shaper #(
    parameter int TICK_DIV    = 1024,
    parameter int SLEW        = 16,
    parameter int DEADZONE    = 32,
    parameter int MIN_DUTY    = 128,
    parameter int DWELL_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_cmd,
    input  logic [11:0] rght_cmd,
    input  logic        cmd_vld,
    input  logic        en,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd,
    output logic        lft_rev,
    output logic        rght_rev,
    output logic        settled
);

    localparam int c_pw = $clog2(TICK_DIV);

    logic [c_pw-1:0] presc_q;
    logic [11:0]     lft_cmd_q;
    logic [11:0]     rght_cmd_q;
    logic            settled_q;

    logic            w_tick;
    logic [10:0]     w_lft_tgt;
    logic [10:0]     w_rght_tgt;
    logic            w_lft_run;
    logic            w_rght_run;

    assign w_tick = (presc_q == c_pw'(TICK_DIV - 1));

    // Free-running slew-tick prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (w_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + c_pw'(1);
        end
    end

    // Capture both wheel commands on the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_cmd_q  <= 12'd0;
            rght_cmd_q <= 12'd0;
        end else if (cmd_vld) begin
            lft_cmd_q  <= lft_cmd;
            rght_cmd_q <= rght_cmd;
        end
    end

    mtr_cmd_side #(
        .SLEW        (SLEW),
        .DEADZONE    (DEADZONE),
        .MIN_DUTY    (MIN_DUTY),
        .DWELL_TICKS (DWELL_TICKS)
    ) u_lft (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_i (w_tick),
        .en_i   (en),
        .cmd_i  (lft_cmd_q),
        .spd_o  (lft_spd),
        .rev_o  (lft_rev),
        .tgt_o  (w_lft_tgt),
        .run_o  (w_lft_run)
    );

    mtr_cmd_side #(
        .SLEW        (SLEW),
        .DEADZONE    (DEADZONE),
        .MIN_DUTY    (MIN_DUTY),
        .DWELL_TICKS (DWELL_TICKS)
    ) u_rght (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_i (w_tick),
        .en_i   (en),
        .cmd_i  (rght_cmd_q),
        .spd_o  (rght_spd),
        .rev_o  (rght_rev),
        .tgt_o  (w_rght_tgt),
        .run_o  (w_rght_run)
    );

    // Settled: both wheels running and sitting on their targets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settled_q <= 1'b1;
        end else begin
            settled_q <= w_lft_run & w_rght_run &
                         (lft_spd == w_lft_tgt) & (rght_spd == w_rght_tgt);
        end
    end

    assign settled = settled_q;

endmodule
`default_nettype wire

// File: tb/tb_mtr_cmd_shaper.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtr_cmd_shaper
// Brief    : Self-checking bench for mtr_cmd_shaper. A cycle-level behavioural
//            model predicts every output; directed scenarios add literal
//            expectations, followed by randomized command/enable traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtr_cmd_shaper;

    localparam int TD = 4;
    localparam int SL = 16;
    localparam int DZ = 32;
    localparam int MD = 128;
    localparam int DW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] lft_cmd = 12'd0;
    logic [11:0] rght_cmd = 12'd0;
    logic        cmd_vld = 1'b0;
    logic        en = 1'b1;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        lft_rev;
    logic        rght_rev;
    logic        settled;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    mtr_cmd_shaper #(
        .TICK_DIV    (TD),
        .SLEW        (SL),
        .DEADZONE    (DZ),
        .MIN_DUTY    (MD),
        .DWELL_TICKS (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_cmd  (lft_cmd),
        .rght_cmd (rght_cmd),
        .cmd_vld  (cmd_vld),
        .en       (en),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lft_rev  (lft_rev),
        .rght_rev (rght_rev),
        .settled  (settled)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 = normal running, 1 = ramping down for a flip, 2 = dwelling
    int m_cmd[2]   = '{0, 0};
    int m_spd[2]   = '{0, 0};
    int m_rev[2]   = '{0, 0};
    int m_ph[2]    = '{0, 0};
    int m_cnt[2]   = '{0, 0};
    int m_presc    = 0;
    int m_settled  = 1;

    function automatic int tgt_of(input int c);
        int mag;
        mag = (c < 0) ? -c : c;
        if (mag < DZ) return 0;
        return (mag + MD > 2047) ? 2047 : mag + MD;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                m_cmd[s] = 0; m_spd[s] = 0; m_rev[s] = 0; m_ph[s] = 0; m_cnt[s] = 0;
            end
            m_presc   = 0;
            m_settled = 1;
        end else begin
            bit tick;
            int t;
            int want;
            tick = (m_presc == TD - 1);
            m_settled = (m_ph[0] == 0 && m_ph[1] == 0 &&
                         m_spd[0] == tgt_of(m_cmd[0]) && m_spd[1] == tgt_of(m_cmd[1])) ? 1 : 0;
            for (int s = 0; s < 2; s++) begin
                t    = tgt_of(m_cmd[s]);
                want = (t == 0) ? m_rev[s] : ((m_cmd[s] < 0) ? 1 : 0);
                if (!en) begin
                    m_spd[s] = 0;
                    m_ph[s]  = 0;
                end else if (tick) begin
                    if (m_ph[s] == 0) begin
                        if (want == m_rev[s]) begin
                            if (m_spd[s] < t) m_spd[s] = (m_spd[s] + SL < t) ? m_spd[s] + SL : t;
                            else              m_spd[s] = (m_spd[s] - SL > t) ? m_spd[s] - SL : t;
                        end else if (m_spd[s] > 0) begin
                            m_ph[s] = 1;
                        end else begin
                            m_ph[s] = 2; m_cnt[s] = DW;
                        end
                    end else if (m_ph[s] == 1) begin
                        if (want == m_rev[s]) m_ph[s] = 0;
                        else begin
                            m_spd[s] = (m_spd[s] > SL) ? m_spd[s] - SL : 0;
                            if (m_spd[s] == 0) begin m_ph[s] = 2; m_cnt[s] = DW; end
                        end
                    end else begin
                        if (want == m_rev[s]) m_ph[s] = 0;
                        else begin
                            m_cnt[s] = m_cnt[s] - 1;
                            if (m_cnt[s] == 0) begin m_rev[s] = 1 - m_rev[s]; m_ph[s] = 0; end
                        end
                    end
                end
            end
            if (cmd_vld) begin
                m_cmd[0] = $signed(lft_cmd);
                m_cmd[1] = $signed(rght_cmd);
            end
            m_presc = tick ? 0 : m_presc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic [10:0] p_lspd, p_rspd;
    logic        p_lrev, p_rrev, p_rst;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("lft_spd",  32'(lft_spd),  m_spd[0]);
            chk("rght_spd", 32'(rght_spd), m_spd[1]);
            chk("lft_rev",  32'(lft_rev),  m_rev[0]);
            chk("rght_rev", 32'(rght_rev), m_rev[1]);
            chk("settled",  32'(settled),  m_settled);
            if (rst_n && p_rst) begin
                if (lft_rev != p_lrev)
                    chk("lft_rev_flip_at_zero", 32'(p_lspd) + 32'(lft_spd), 0);
                if (rght_rev != p_rrev)
                    chk("rght_rev_flip_at_zero", 32'(p_rspd) + 32'(rght_spd), 0);
            end
        end
        p_lspd = lft_spd; p_rspd = rght_spd;
        p_lrev = lft_rev; p_rrev = rght_rev; p_rst = rst_n;
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic strobe(input int l, input int r);
        lft_cmd  = l[11:0];
        rght_cmd = r[11:0];
        cmd_vld  = 1'b1;
        @(negedge clk);
        cmd_vld  = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TD) @(negedge clk);
    endtask

    task automatic pulse_reset;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_lft_spd",  32'(lft_spd),  0);
        chk("async_rst_rght_spd", 32'(rght_spd), 0);
        chk("async_rst_lft_rev",  32'(lft_rev),  0);
        chk("async_rst_rght_rev", 32'(rght_rev), 0);
        chk("async_rst_settled",  32'(settled),  1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_lft(input int val, input int budget, input string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (lft_spd == 11'(val)) found = 1'b1;
        end
        chk(nm, 32'(found), 1);
    endtask

    function automatic int rnd_cmd();
        case ($urandom_range(0, 7))
            0: return -2048;
            1: return 2047;
            2: return ($urandom_range(0, 1) != 0) ? 31 : -31;
            3: return ($urandom_range(0, 1) != 0) ? 32 : -32;
            4: return 0;
            default: return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        // Idle after reset
        wait_ticks(2);
        chk("idle_lft_spd", 32'(lft_spd), 0);
        chk("idle_lft_rev", 32'(lft_rev), 0);
        chk("idle_settled", 32'(settled), 1);

        // Ramp up to 400+128
        strobe(400, 0);
        wait_ticks(36);
        chk("up_lft_spd", 32'(lft_spd), 528);
        chk("up_settled", 32'(settled), 1);
        chk("up_lft_rev", 32'(lft_rev), 0);

        // Deadzone command ramps to zero without reversal
        strobe(20, 0);
        wait_ticks(36);
        chk("dz_lft_spd", 32'(lft_spd), 0);
        chk("dz_lft_rev", 32'(lft_rev), 0);

        // Full reversal 528 forward -> 528 reverse
        strobe(400, 0);
        wait_ticks(36);
        chk("pre_rev_lft_spd", 32'(lft_spd), 528);
        strobe(-400, 0);
        wait_ticks(75);
        chk("rev_lft_spd", 32'(lft_spd), 528);
        chk("rev_lft_rev", 32'(lft_rev), 1);

        // Right wheel at full negative, then full positive
        strobe(-400, -2048);
        wait_ticks(140);
        chk("r_neg_spd", 32'(rght_spd), 2047);
        chk("r_neg_rev", 32'(rght_rev), 1);
        strobe(-400, 2047);
        wait_ticks(270);
        chk("r_pos_spd", 32'(rght_spd), 2047);
        chk("r_pos_rev", 32'(rght_rev), 0);
        chk("r_pos_settled", 32'(settled), 1);

        // Asynchronous reset with both wheels moving, then enable drop mid-ramp
        pulse_reset();
        strobe(400, 0);
        wait_lft(256, 200, "reach_256");
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_lft_spd", 32'(lft_spd), 0);
        wait_ticks(2);
        en = 1'b1;
        wait_ticks(40);
        chk("en_resume_lft_spd", 32'(lft_spd), 528);

        // Command returns positive during dwell: no flip
        pulse_reset();
        strobe(400, 0);
        wait_ticks(36);
        strobe(-400, 0);
        wait_lft(0, 300, "reach_zero");
        strobe(400, 0);
        wait_ticks(40);
        chk("dwell_abort_rev", 32'(lft_rev), 0);
        chk("dwell_abort_spd", 32'(lft_spd), 528);

        // Randomized traffic, model-checked every cycle
        for (int it = 0; it < 250; it++) begin
            if (it == 125) pulse_reset();
            if ($urandom_range(0, 3) != 0) begin
                lft_cmd  = 12'(rnd_cmd());
                rght_cmd = 12'(rnd_cmd());
                cmd_vld  = 1'b1;
                @(negedge clk);
                cmd_vld  = 1'b0;
            end
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) repeat (600) @(negedge clk);
            else repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        en = 1'b1;
        wait_ticks(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mtr_cmd_shaper.md
# mtr_cmd_shaper

Conditions signed per-wheel drive commands into the magnitude/direction form consumed by the motor driver (11-bit `lft_spd`/`rght_spd` plus `lft_rev`/`rght_rev`). The block sits directly upstream of the motor driver, after the balance controller. Per wheel it applies deadzone rejection, minimum-duty offset, saturation and slew-rate limiting. Any direction reversal is forced through zero speed with a dwell period, so the H-bridge never sees an instantaneous direction flip at nonzero duty.

## Interface
- TICK_DIV, 1024, clocks per slew tick (≥2)
- SLEW, 16, max magnitude change per tick (1..2047)
- DEADZONE, 32, |cmd| below this gives target 0
- MIN_DUTY, 128, offset added to |cmd| when outside deadzone
- DWELL_TICKS, 8, ticks held at zero speed before a direction flip (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lft_cmd  in  12  signed two's-complement left drive command
- rght_cmd  in  12  signed right drive command
- cmd_vld  in  1  one-cycle strobe; latches both commands
- en  in  1  drive enable; low forces zero speed
- lft_spd  out  11  left magnitude to motor driver
- rght_spd  out  11  right magnitude
- lft_rev  out  1  left direction, 1 = reverse
- rght_rev  out  1  right direction
- settled  out  1  both sides in RUN with spd == target

## Operation
- Reset: lft_spd = rght_spd = 0, lft_rev = rght_rev = 0, settled = 1, both sides in RUN, prescaler = 0, latched commands = 0.
- Latch: on cmd_vld, both cmd inputs are registered. Targets are derived combinationally from the latched values.
- Target per side:
  - mag = |cmd| in 12-bit unsigned. −2048 gives 2048.
  - If mag < DEADZONE, tgt = 0. Otherwise tgt = min(mag + MIN_DUTY, 2047), computed at 13 bits and then saturated.
  - tdir = sign bit of cmd. When tgt = 0, tdir = current rev (no reversal requested).
- Prescaler: counts 0..TICK_DIV−1 and wraps. `tick` is high for the single cycle where count == TICK_DIV−1. All speed, rev and dwell updates occur only on tick cycles.
- Per-side FSM (independent instances): RUN, RAMP_DN, DWELL.
  - RUN:
    - If tdir == rev, step spd toward tgt by at most SLEW and land exactly on tgt; never overshoot.
    - If tdir != rev and spd > 0, go to RAMP_DN.
    - If tdir != rev and spd == 0, go to DWELL and load dwell counter = DWELL_TICKS.
  - RAMP_DN:
    - Each tick, spd = max(spd − SLEW, 0). When the result is 0, go to DWELL and load the counter.
    - If tdir returns to rev, go to RUN; the ramp resumes toward tgt from the next tick.
  - DWELL:
    - spd held at 0; the counter decrements each tick.
    - If tdir returns to rev, go to RUN with no flip.
    - When the counter reaches 0, toggle rev and go to RUN. Ramp-up starts on the following tick.
- en low:
  - Both spd outputs are 0 on the next clock edge, independent of tick.
  - FSMs are forced to RUN and rev holds its value. Latched commands are kept.
  - When en rises, ramping restarts from 0 (including any pending reversal via the normal RUN rules).
- settled: registered; equals (both FSMs in RUN) & (lft_spd == lft tgt) & (rght_spd == rght tgt).

## Timing
- All outputs are registered and there is no combinational path from inputs to outputs.
- A command latched at cycle N takes effect at the first tick after N. If cmd_vld and tick fall in the same cycle, the new command is used from the next tick onward.
- Ramp time from 0 to tgt is ceil(tgt/SLEW) ticks.
- Full reversal sequence: ceil(spd/SLEW) ramp ticks, then DWELL_TICKS ticks at 0, then rev toggles on the last dwell tick. First nonzero spd appears one tick later.
- rev changes only while spd == 0 and never in the same cycle that spd changes.
- Asynchronous reset mid-ramp or mid-dwell returns every register to its reset value immediately.

## Test plan
Bench parameters: TICK_DIV=4, SLEW=16, DEADZONE=32, MIN_DUTY=128, DWELL_TICKS=2.
- Reset, then idle with en=1 → all spd outputs 0, rev 0, settled 1.
- lft_cmd=+400 strobed → lft_spd goes 16, 32, … one step per 4 clocks. It reaches 528 after 33 ticks, then settled=1; lft_rev stays 0.
- lft_cmd=+20 from spd 528 → target 0 (deadzone). spd ramps down to 0 in 33 ticks and rev stays 0.
- From spd 528 forward, lft_cmd=−400:
  - RAMP_DN to 0 over 33 ticks, then 2 ticks of DWELL at 0.
  - lft_rev=1 after the dwell, then ramp-up to 528.
  - No cycle may show spd≠0 coincident with a rev change.
- rght_cmd=−2048 → rght_spd settles at 2047 with rev=1. rght_cmd=+2047 → reversal sequence, then settles at 2047 with rev=0.
- Drop en mid-ramp at lft_spd=256 → lft_spd=0 on the next edge. In a separate run, return the cmd to positive during DWELL → RUN with rev unchanged (0).
